// File: rtl/hazard_scoreboard.sv
// Purpose: pipeline hazard unit; shadows E/M/W writers, produces stall and D/E forward selects.
// Latency: stall and all selects are combinational in the same cycle; shadow entries update on clk.
// Backpressure: stall=1 holds PC/F2D and loads a bubble into the E shadow and E source registers.
module hazard_scoreboard #(
  parameter int TW   = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      A1_D,
  input  logic [4:0]      A2_D,
  input  logic            use_rs_D,
  input  logic            use_rt_D,
  input  logic [TW-1:0]   Tuse_rs_D,
  input  logic [TW-1:0]   Tuse_rt_D,
  input  logic [4:0]      A3_D,
  input  logic            RegWrite_D,
  input  logic [TW-1:0]   Tnew_D,
  output logic            stall,
  output logic [1:0]      fwd_rs_D,
  output logic [1:0]      fwd_rt_D,
  output logic [1:0]      fwd_rs_E,
  output logic [1:0]      fwd_rt_E,
  output logic [CNTW-1:0] stall_count
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    addr;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t          e_q, e_d, m_q, m_d, w_q, w_d;
  logic [4:0]      a1_e_q, a1_e_d, a2_e_q, a2_e_d;
  logic            use_rs_e_q, use_rs_e_d, use_rt_e_q, use_rt_e_d;
  logic [CNTW-1:0] stall_count_q, stall_count_d;
  logic            stall_rs, stall_rt;

  // Register 0 is hardwired, so it can never be a producer for any reader.
  function automatic logic hit(entry_t en, logic [4:0] src, logic use_src);
    return en.valid && (en.addr == src) && (src != 5'd0) && use_src;
  endfunction

  function automatic logic [TW-1:0] dec_sat(logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // The youngest matching writer decides: stall if its result is later than the reader needs it.
  function automatic logic src_stall(entry_t e, entry_t m, entry_t w,
                                     logic [4:0] src, logic use_src, logic [TW-1:0] tuse);
    logic r;
    r = 1'b0;
    if (hit(e, src, use_src))      r = (e.tnew > tuse);
    else if (hit(m, src, use_src)) r = (m.tnew > tuse);
    else if (hit(w, src, use_src)) r = (w.tnew > tuse);
    return r;
  endfunction

  // A younger writer that is not ready yet masks older matches; the stall covers that case.
  function automatic logic [1:0] sel_d(entry_t e, entry_t m, entry_t w,
                                       logic [4:0] src, logic use_src);
    logic [1:0] r;
    r = 2'd0;
    if (hit(e, src, use_src))      r = (e.tnew == '0) ? 2'd1 : 2'd0;
    else if (hit(m, src, use_src)) r = (m.tnew == '0) ? 2'd2 : 2'd0;
    else if (hit(w, src, use_src)) r = 2'd3;
    return r;
  endfunction

  // In E only M and W can supply; an M writer still pending here would be an upstream stall bug.
  function automatic logic [1:0] sel_e(entry_t m, entry_t w, logic [4:0] src, logic use_src);
    logic [1:0] r;
    r = 2'd0;
    if (hit(m, src, use_src))      r = 2'd2;
    else if (hit(w, src, use_src)) r = 2'd3;
    return r;
  endfunction

  // Hazard detection and forward selection from the current shadow and D/E sources.
  always_comb begin
    stall_rs = src_stall(e_q, m_q, w_q, A1_D, use_rs_D, Tuse_rs_D);
    stall_rt = src_stall(e_q, m_q, w_q, A2_D, use_rt_D, Tuse_rt_D);
    stall    = stall_rs | stall_rt;
    fwd_rs_D = sel_d(e_q, m_q, w_q, A1_D, use_rs_D);
    fwd_rt_D = sel_d(e_q, m_q, w_q, A2_D, use_rt_D);
    fwd_rs_E = sel_e(m_q, w_q, a1_e_q, use_rs_e_q);
    fwd_rt_E = sel_e(m_q, w_q, a2_e_q, use_rt_e_q);
    stall_count = stall_count_q;
  end

  // Next shadow state: age writers one stage, load E from D or insert a bubble.
  always_comb begin
    w_d        = m_q;
    w_d.tnew   = dec_sat(m_q.tnew);
    m_d        = e_q;
    m_d.tnew   = dec_sat(e_q.tnew);
    e_d        = '0;
    a1_e_d     = 5'd0;
    a2_e_d     = 5'd0;
    use_rs_e_d = 1'b0;
    use_rt_e_d = 1'b0;
    if (!stall) begin
      e_d.valid  = RegWrite_D && (A3_D != 5'd0);
      e_d.addr   = A3_D;
      e_d.tnew   = Tnew_D;
      a1_e_d     = A1_D;
      a2_e_d     = A2_D;
      use_rs_e_d = use_rs_D;
      use_rt_e_d = use_rt_D;
    end
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNTW{1'b1}})) stall_count_d = stall_count_q + CNTW'(1);
  end

  // Shadow registers; reset clears every entry, which drops any stall at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q           <= '0;
      m_q           <= '0;
      w_q           <= '0;
      a1_e_q        <= 5'd0;
      a2_e_q        <= 5'd0;
      use_rs_e_q    <= 1'b0;
      use_rt_e_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      e_q           <= e_d;
      m_q           <= m_d;
      w_q           <= w_d;
      a1_e_q        <= a1_e_d;
      a2_e_q        <= a2_e_d;
      use_rs_e_q    <= use_rs_e_d;
      use_rt_e_q    <= use_rt_e_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
